qracc_bus_initiator: RTL and testbench

// - Bus initiator for the QRAcc data/control bus: drives address, write data and read/write strobes into the accelerator's slave port.
// - Executes word-burst commands (write stream, read stream, or CSR poll) from a host command port.
// - Returns read data on a valid/ready stream; used by the SoC wrapper and by the top-level bench in place of the CPU.

---
 rtl/qracc_bus_initiator.sv | 200 ++++++++++++++++++++
 tb/tb_qracc_bus_initiator.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qracc_bus_initiator.sv
// QRAcc bus initiator: runs WRITE/READ word bursts and CSR polls issued on a host command port.
// Optional read-response timeout is compiled in when QRACC_BUS_TIMEOUT_EN is defined.

module qracc_bus_initiator #(
  parameter int unsigned dataWidth     = 32,
  parameter int unsigned addrWidth     = 32,
  parameter int unsigned lenWidth      = 8,
  parameter int unsigned addrStride    = 4,
  parameter int unsigned timeoutCycles = 64
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [addrWidth-1:0] cmd_addr_i,
  input  logic [lenWidth-1:0]  cmd_len_i,
  input  logic [dataWidth-1:0] cmd_mask_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic [dataWidth-1:0] wdata_i,
  output logic                 rdata_valid_o,
  input  logic                 rdata_ready_i,
  output logic [dataWidth-1:0] rdata_o,
  output logic [addrWidth-1:0] bus_addr_o,
  output logic [dataWidth-1:0] bus_data_o,
  output logic                 bus_wen_o,
  output logic                 bus_ren_o,
  input  logic [dataWidth-1:0] bus_data_i,
  input  logic                 bus_rvalid_i,
  output logic                 done_o,
  output logic                 err_o
);

  if (timeoutCycles < 2) begin : g_bad_timeout
    $error("timeoutCycles must be at least 2");
  end

  typedef enum logic [3:0] {
    StIdle,
    StWr,
    StRdReq,
    StRdWait,
    StRdOut,
    StPollReq,
    StPollWait,
    StPollGap,
    StDone
  } state_e;

  localparam logic [addrWidth-1:0] Stride = addrWidth'(addrStride);
  localparam logic [lenWidth-1:0]  LenOne = lenWidth'(1);

  state_e               state_q, state_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic [lenWidth-1:0]  len_q, len_d;
  logic [dataWidth-1:0] mask_q, mask_d;
  logic [dataWidth-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;

`ifdef QRACC_BUS_TIMEOUT_EN
  localparam int unsigned         TmoW    = $clog2(timeoutCycles);
  localparam logic [TmoW-1:0]     TmoLast = TmoW'(timeoutCycles - 2);
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    mask_d        = mask_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    wdata_ready_o = 1'b0;
    bus_wen_o     = 1'b0;
    bus_ren_o     = 1'b0;
    bus_data_o    = '0;
    rdata_valid_o = 1'b0;
    done_o        = 1'b0;
`ifdef QRACC_BUS_TIMEOUT_EN
    tmo_d         = '0;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i && ready_q) begin
          addr_d = cmd_addr_i;
          len_d  = cmd_len_i;
          mask_d = cmd_mask_i;
          err_d  = 1'b0;
          case (cmd_op_i)
            2'd0:    state_d = (cmd_len_i == '0) ? StDone : StWr;
            2'd1:    state_d = (cmd_len_i == '0) ? StDone : StRdReq;
            2'd2:    state_d = StPollReq;
            default: begin
              err_d   = 1'b1;
              state_d = StDone;
            end
          endcase
        end
      end
      StWr: begin
        wdata_ready_o = 1'b1;
        bus_wen_o     = wdata_valid_i;
        bus_data_o    = wdata_i;
        if (wdata_valid_i) begin
          addr_d = addr_q + Stride;
          len_d  = len_q - LenOne;
          if (len_q == LenOne) state_d = StDone;
        end
      end
      StRdReq: begin
        bus_ren_o = 1'b1;
        state_d   = StRdWait;
      end
      StRdWait: begin
        if (bus_rvalid_i) begin
          rdata_d = bus_data_i;
          state_d = StRdOut;
        end
`ifdef QRACC_BUS_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
`endif
      end
      StRdOut: begin
        // rdata_q is only reloaded in StRdWait, so the word stays stable under back-pressure.
        rdata_valid_o = 1'b1;
        if (rdata_ready_i) begin
          addr_d  = addr_q + Stride;
          len_d   = len_q - LenOne;
          state_d = (len_q == LenOne) ? StDone : StRdReq;
        end
      end
      StPollReq: begin
        bus_ren_o = 1'b1;
        state_d   = StPollWait;
      end
      StPollWait: begin
        if (bus_rvalid_i) begin
          state_d = ((bus_data_i & mask_q) == '0) ? StDone : StPollGap;
        end
`ifdef QRACC_BUS_TIMEOUT_EN
        else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
`endif
      end
      StPollGap: state_d = StPollReq;
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Registered so that cmd_ready_o is 0 while in reset and rises with the first idle cycle.
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
`ifdef QRACC_BUS_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ready_q <= ready_d;
`ifdef QRACC_BUS_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign cmd_ready_o = ready_q;
  assign bus_addr_o  = addr_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_qracc_bus_initiator.sv
// Self-checking bench for qracc_bus_initiator: slave/sink models, vector table, hand sequences
// and randomized bursts checked against an address/memory reference model.

module tb_qracc_bus_initiator;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned STRIDE = 4;
  localparam int unsigned TMO = 64;

  logic          clk, nrst;
  logic          cmd_valid_i, cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [AW-1:0] cmd_addr_i;
  logic [LW-1:0] cmd_len_i;
  logic [DW-1:0] cmd_mask_i;
  logic          wdata_valid_i, wdata_ready_o;
  logic [DW-1:0] wdata_i;
  logic          rdata_valid_o, rdata_ready_i;
  logic [DW-1:0] rdata_o;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_data_o;
  logic          bus_wen_o, bus_ren_o;
  logic [DW-1:0] bus_data_i;
  logic          bus_rvalid_i;
  logic          done_o, err_o;

  qracc_bus_initiator #(
    .dataWidth    (DW),
    .addrWidth    (AW),
    .lenWidth     (LW),
    .addrStride   (STRIDE),
    .timeoutCycles(TMO)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_len_i    (cmd_len_i),
    .cmd_mask_i   (cmd_mask_i),
    .wdata_valid_i(wdata_valid_i),
    .wdata_ready_o(wdata_ready_o),
    .wdata_i      (wdata_i),
    .rdata_valid_o(rdata_valid_o),
    .rdata_ready_i(rdata_ready_i),
    .rdata_o      (rdata_o),
    .bus_addr_o   (bus_addr_o),
    .bus_data_o   (bus_data_o),
    .bus_wen_o    (bus_wen_o),
    .bus_ren_o    (bus_ren_o),
    .bus_data_i   (bus_data_i),
    .bus_rvalid_i (bus_rvalid_i),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] mask;
    int          exp_strobes;
    bit          exp_err;
  } vec_t;

  // Observation logs
  wr_t         wen_log[$];
  int          wen_cyc[$];
  logic [31:0] ren_log[$];
  int          ren_cyc[$];
  logic [31:0] rd_log[$];
  int          rd_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          cyc = 0;
  bit          overlap = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;

  // Slave / sink models and reference memory
  logic [31:0] slave_mem[logic [31:0]];
  logic [31:0] model_mem[logic [31:0]];
  logic [31:0] poll_q[$];
  logic [31:0] wq[$];
  bit          s_busy = 0;
  int          s_cnt = 0;
  logic [31:0] s_addr = '0;
  bit          s_mute = 0;
  bit          poll_mode = 0;
  bit          spur_en = 0;
  int          s_lat_min = 2;
  int          s_lat_max = 2;
  bit          rnd_ready = 0;
  int          stall_word = -1;
  int          stall_left = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (nrst) begin
        if (bus_wen_o && bus_ren_o) overlap = 1;
        if (bus_wen_o) begin
          wen_log.push_back('{a: bus_addr_o, d: bus_data_o});
          wen_cyc.push_back(cyc);
          slave_mem[bus_addr_o] = bus_data_o;
        end
        if (bus_ren_o) begin
          ren_log.push_back(bus_addr_o);
          ren_cyc.push_back(cyc);
          s_busy = 1;
          s_cnt  = $urandom_range(s_lat_max, s_lat_min);
          s_addr = bus_addr_o;
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (rdata_valid_o && prev_stall) check("rdata_hold", rdata_o, prev_data);
        prev_stall = rdata_valid_o && !rdata_ready_i;
        prev_data  = rdata_o;
        if (rdata_valid_o && rdata_ready_i) begin
          rd_log.push_back(rdata_o);
          rd_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    bus_rvalid_i  = 1'b0;
    bus_data_i    = '0;
    rdata_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_rvalid_i = 1'b0;
      bus_data_i   = $urandom;
      if (!nrst) begin
        s_busy = 0;
      end else if (s_busy && !s_mute) begin
        s_cnt--;
        if (s_cnt <= 0) begin
          bus_rvalid_i = 1'b1;
          if (poll_mode) bus_data_i = (poll_q.size() != 0) ? poll_q.pop_front() : 32'h0;
          else bus_data_i = slave_mem.exists(s_addr) ? slave_mem[s_addr] : ~s_addr;
          s_busy = 0;
        end
      end else if (!s_busy && spur_en && ($urandom_range(3, 0) == 0)) begin
        bus_rvalid_i = 1'b1;
      end
      if (rdata_valid_o && stall_left > 0 && rd_log.size() == stall_word) begin
        rdata_ready_i = 1'b0;
        stall_left--;
      end else begin
        rdata_ready_i = rnd_ready ? ($urandom_range(2, 0) != 0) : 1'b1;
      end
    end
  end

  task automatic clear_logs();
    wen_log.delete();
    wen_cyc.delete();
    ren_log.delete();
    ren_cyc.delete();
    rd_log.delete();
    rd_cyc.delete();
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [7:0] len,
                          input logic [31:0] mask);
    int n;
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = addr;
    cmd_len_i   = len;
    cmd_mask_i  = mask;
    @(negedge clk);
    n = 0;
    while (!cmd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) check("cmd_accept_timeout", cmd_ready_o, 1);
    @(posedge clk);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic feed_words(input int n, input int gap_idx, input bit rnd_gap);
    int g;
    int k;
    for (int i = 0; i < n; i++) begin
      g = (i == gap_idx) ? 1 : 0;
      if (rnd_gap && $urandom_range(2, 0) == 0) g = $urandom_range(2, 1);
      repeat (g) begin
        wdata_valid_i = 1'b0;
        @(posedge clk);
        #1;
      end
      wdata_valid_i = 1'b1;
      wdata_i       = wq[i];
      @(negedge clk);
      k = 0;
      while (!wdata_ready_o && k < 100) begin
        @(negedge clk);
        k++;
      end
      if (!wdata_ready_o) check("wdata_accept_timeout", wdata_ready_o, 1);
      @(posedge clk);
      #1;
    end
    wdata_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) check("done_wait_timeout", done_cnt - d0, 1);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [7:0] len,
                         input logic [31:0] mask, input bit rnd_gap, input int gap_idx,
                         input bit preset);
    int          d0;
    int          exp_ren;
    logic [31:0] a;
    logic [31:0] exp_d;
    logic [31:0] pq[$];
    clear_logs();
    if (!preset) begin
      wq.delete();
      if (op == 2'd0) for (int i = 0; i < int'(len); i++) wq.push_back($urandom);
    end
    pq        = poll_q;
    poll_mode = (op == 2'd2);
    d0        = done_cnt;
    send_cmd(op, addr, len, mask);
    if (op == 2'd0 && len != 0) feed_words(int'(len), gap_idx, rnd_gap);
    wait_done(d0);
    repeat (2) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("err_after_cmd", err_o, (op == 2'd3));
    case (op)
      2'd0: begin
        check("wen_count", wen_log.size(), len);
        check("wr_no_ren", ren_log.size(), 0);
        for (int i = 0; i < int'(len) && i < wen_log.size(); i++) begin
          a = addr + 32'(i * STRIDE);
          check("wen_addr", wen_log[i].a, a);
          check("wen_data", wen_log[i].d, wq[i]);
          model_mem[a] = wq[i];
        end
      end
      2'd1: begin
        check("ren_count", ren_log.size(), len);
        check("rd_no_wen", wen_log.size(), 0);
        check("rd_words", rd_log.size(), len);
        for (int i = 0; i < int'(len) && i < ren_log.size(); i++) begin
          a = addr + 32'(i * STRIDE);
          check("ren_addr", ren_log[i], a);
          if (i < rd_log.size()) begin
            exp_d = model_mem.exists(a) ? model_mem[a] : ~a;
            check("rdata", rd_log[i], exp_d);
          end
        end
      end
      2'd2: begin
        exp_ren = 0;
        for (int i = 0; i < pq.size(); i++) begin
          exp_ren++;
          if ((pq[i] & mask) == 0) break;
        end
        check("poll_ren_count", ren_log.size(), exp_ren);
        for (int i = 0; i < ren_log.size(); i++) check("poll_addr", ren_log[i], addr);
        check("poll_no_wen", wen_log.size(), 0);
        check("poll_no_words", rd_log.size(), 0);
      end
      default: check("rsvd_no_bus", wen_log.size() + ren_log.size(), 0);
    endcase
    poll_mode = 0;
    poll_q.delete();
  endtask

  vec_t        vecs[10];
  int          d0;
  int          r;
  int          k;
  logic [1:0]  op;
  logic [31:0] addr;
  logic [31:0] mask;
  logic [7:0]  len;

  initial begin
    #900_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, 32'h0000_0200, 8'd0,   32'h0, 0,   1'b0};
    vecs[1] = '{2'd3, 32'h0000_0300, 8'd5,   32'h0, 0,   1'b1};
    vecs[2] = '{2'd1, 32'h0000_0200, 8'd0,   32'h0, 0,   1'b0};
    vecs[3] = '{2'd0, 32'hFFFF_FFF8, 8'd3,   32'h0, 3,   1'b0};
    vecs[4] = '{2'd1, 32'hFFFF_FFF8, 8'd3,   32'h0, 3,   1'b0};
    vecs[5] = '{2'd3, 32'h0000_0000, 8'd0,   32'h0, 0,   1'b1};
    vecs[6] = '{2'd0, 32'h0000_0040, 8'd1,   32'h0, 1,   1'b0};
    vecs[7] = '{2'd1, 32'h0000_0040, 8'd1,   32'h0, 1,   1'b0};
    vecs[8] = '{2'd0, 32'h0000_1000, 8'd255, 32'h0, 255, 1'b0};
    vecs[9] = '{2'd1, 32'h0000_1000, 8'd255, 32'h0, 255, 1'b0};

    nrst          = 1'b0;
    cmd_valid_i   = 1'b0;
    cmd_op_i      = '0;
    cmd_addr_i    = '0;
    cmd_len_i     = '0;
    cmd_mask_i    = '0;
    wdata_valid_i = 1'b0;
    wdata_i       = '0;

    #2;
    check("reset_ctrl", {cmd_ready_o, wdata_ready_o, rdata_valid_o, bus_wen_o, bus_ren_o,
                         done_o, err_o}, 0);
    check("reset_addr", bus_addr_o, 0);
    check("reset_wdata", bus_data_o, 0);
    check("reset_rdata", rdata_o, 0);
    repeat (3) @(negedge clk);
    check("reset_ready_held_low", cmd_ready_o, 0);
    nrst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready_o, 1);

    // WRITE 0x100 x4 with a one-cycle gap before the third word
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(32'h0000_00A0 + 32'(i));
    run_cmd(2'd0, 32'h0000_0100, 8'd4, 32'h0, 1'b0, 2, 1'b1);
    if (wen_cyc.size() == 4) begin
      check("wen_back_to_back", wen_cyc[1] - wen_cyc[0], 1);
      check("wen_gap", wen_cyc[2] - wen_cyc[1], 2);
    end

    // READ 0x100 x3, slave latency 2, sink stalls 3 cycles on word 1
    s_lat_min  = 2;
    s_lat_max  = 2;
    stall_word = 1;
    stall_left = 3;
    run_cmd(2'd1, 32'h0000_0100, 8'd3, 32'h0, 1'b0, -1, 1'b0);
    check("stall_applied", stall_left, 0);
    if (rd_cyc.size() == 3) check("done_after_last_word", done_cyc - rd_cyc[2], 1);
    stall_word = -1;

    // POLL 0x10 mask 1, responses 1,1,0
    poll_q = '{32'h1, 32'h1, 32'h0};
    run_cmd(2'd2, 32'h0000_0010, 8'd0, 32'h1, 1'b0, -1, 1'b0);

    // Vector table with random latency, sink back-pressure and stray rvalid pulses
    s_lat_min = 1;
    s_lat_max = 3;
    rnd_ready = 1;
    spur_en   = 1;
    for (int i = 0; i < 10; i++) begin
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].mask, 1'b1, -1, 1'b0);
      check("vec_strobes", wen_log.size() + ren_log.size(), vecs[i].exp_strobes);
      check("vec_err", err_o, vecs[i].exp_err);
    end

    // Asynchronous reset during word 2 of an 8-word WRITE
    spur_en = 0;
    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back($urandom);
    clear_logs();
    d0 = done_cnt;
    send_cmd(2'd0, 32'h0000_0500, 8'd8, 32'h0);
    feed_words(2, -1, 1'b0);
    wdata_valid_i = 1'b1;
    wdata_i       = wq[2];
    #2;
    check("pre_reset_wen", bus_wen_o, 1);
    nrst = 1'b0;
    #1;
    check("abort_ctrl", {cmd_ready_o, wdata_ready_o, rdata_valid_o, bus_wen_o, bus_ren_o,
                         done_o, err_o}, 0);
    check("abort_addr", bus_addr_o, 0);
    check("abort_wdata", bus_data_o, 0);
    wdata_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_partial_words", wen_log.size(), 2);
    model_mem[32'h0000_0500] = wq[0];
    model_mem[32'h0000_0504] = wq[1];
    run_cmd(2'd1, 32'h0000_0500, 8'd2, 32'h0, 1'b0, -1, 1'b0);
    run_cmd(2'd0, 32'h0000_0600, 8'd3, 32'h0, 1'b1, -1, 1'b0);

`ifdef QRACC_BUS_TIMEOUT_EN
    s_mute = 1;
    clear_logs();
    d0 = done_cnt;
    send_cmd(2'd1, 32'h0000_0700, 8'd2, 32'h0);
    wait_done(d0);
    repeat (2) @(negedge clk);
    check("tmo_ren", ren_log.size(), 1);
    if (ren_cyc.size() != 0) check("tmo_latency", done_cyc - ren_cyc[0], TMO);
    check("tmo_err", err_o, 1);
    check("tmo_no_words", rd_log.size(), 0);
    s_mute = 0;
    s_busy = 0;
    run_cmd(2'd1, 32'h0000_0100, 8'd1, 32'h0, 1'b0, -1, 1'b0);
`endif

    // Randomized bursts against the reference memory model
    s_lat_min = 1;
    s_lat_max = 4;
    spur_en   = 1;
    for (int it = 0; it < 40; it++) begin
      r    = $urandom_range(9, 0);
      op   = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      addr = 32'h0000_2000 + 32'($urandom_range(31, 0)) * 4;
      len  = 8'($urandom_range(8, 1));
      mask = $urandom | 32'h1;
      if (op == 2'd2) begin
        k = $urandom_range(3, 0);
        for (int j = 0; j < k; j++) poll_q.push_back($urandom | 32'h1);
        poll_q.push_back($urandom & ~mask);
      end
      run_cmd(op, addr, len, mask, 1'b1, -1, 1'b0);
    end

    check("wen_ren_exclusive", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
